// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register.
module fetch_stage #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic [1:0] pc_src,
  input  logic [31:0] imm_op,
  input  logic [31:0] jalr_base,
  output logic [ADDRESS_WIDTH-1:0] pc_addr,
  input  logic [DATA_WIDTH-1:0] instr_in,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4,
  output logic if_id_valid,
  output logic [31:0] fetch_count
);
  logic [ADDRESS_WIDTH-1:0] pc, pc_plus4, rel_target, ind_target, target;
  logic [31:0] jalr_sum;
  logic redirect;
  assign pc_addr = pc;
  assign pc_plus4 = pc + ADDRESS_WIDTH'(4);
  assign rel_target = if_id_pc + ADDRESS_WIDTH'(imm_op);
  assign jalr_sum = jalr_base + imm_op;
  // JALR targets are forced word-aligned so fetch never straddles a word
  assign ind_target = ADDRESS_WIDTH'({jalr_sum[31:2], 2'b00});
  assign redirect = pc_src[0] ^ pc_src[1];
  assign target = pc_src[0] ? rel_target : ind_target;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (!stall) begin
      if (redirect) begin
        pc <= target;
        if_id_instr <= NOP_INSTR;
        if_id_pc <= '0;
        if_id_pc_plus4 <= '0;
        if_id_valid <= 1'b0;
      end else begin
        pc <= pc_plus4;
        if_id_instr <= instr_in;
        if_id_pc <= pc;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, async-reset sequence and randomized run against a reference model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk, rst, stall, if_id_valid;
  logic [1:0] pc_src;
  logic [31:0] imm_op, jalr_base, pc_addr, instr_in, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
  int errors = 0, checks = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .imm_op(imm_op),
    .jalr_base(jalr_base), .pc_addr(pc_addr), .instr_in(instr_in),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a == 32'd0 ? 32'h0050_0093 : a * 32'h9E37_79B1 + 32'd1;
  endfunction

  assign instr_in = imem(pc_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] ipc, input logic [31:0] ipc4, input logic v, input logic [31:0] cnt);
    chk({tag, ".pc_addr"}, pc_addr, pc);
    chk({tag, ".if_id_instr"}, if_id_instr, ins);
    chk({tag, ".if_id_pc"}, if_id_pc, ipc);
    chk({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, ipc4);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  typedef struct {
    logic st;
    logic [1:0] src;
    logic [31:0] imm, jb, e_pc, e_ipc;
    logic e_v;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic m_valid;

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 32'd0, 32'd0, 32'h4, 32'h0, 1'b1, 32'd1};
    vecs[1]  = '{1'b0, 2'b00, 32'd0, 32'd0, 32'h8, 32'h4, 1'b1, 32'd2};
    vecs[2]  = '{1'b0, 2'b00, 32'd0, 32'd0, 32'hC, 32'h8, 1'b1, 32'd3};
    vecs[3]  = '{1'b0, 2'b01, 32'hFFFF_FFF8, 32'd0, 32'h0, 32'h0, 1'b0, 32'd3};
    vecs[4]  = '{1'b0, 2'b00, 32'd0, 32'd0, 32'h4, 32'h0, 1'b1, 32'd4};
    vecs[5]  = '{1'b0, 2'b10, 32'h4, 32'h103, 32'h104, 32'h0, 1'b0, 32'd4};
    vecs[6]  = '{1'b1, 2'b01, 32'h100, 32'd0, 32'h104, 32'h0, 1'b0, 32'd4};
    vecs[7]  = '{1'b1, 2'b01, 32'h100, 32'd0, 32'h104, 32'h0, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 2'b00, 32'd0, 32'd0, 32'h108, 32'h104, 1'b1, 32'd5};
    vecs[9]  = '{1'b0, 2'b10, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'd5};
    vecs[10] = '{1'b0, 2'b00, 32'd0, 32'd0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'd6};
    vecs[11] = '{1'b0, 2'b11, 32'h40, 32'h80, 32'h4, 32'h0, 1'b1, 32'd7};

    rst = 1'b1; stall = 1'b0; pc_src = 2'b00; imm_op = '0; jalr_base = '0;
    #12;
    chk_all("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].st; pc_src = vecs[i].src; imm_op = vecs[i].imm; jalr_base = vecs[i].jb;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc,
              vecs[i].e_v ? imem(vecs[i].e_ipc) : NOP, vecs[i].e_ipc,
              vecs[i].e_v ? vecs[i].e_ipc + 32'd4 : 32'd0, vecs[i].e_v, vecs[i].e_cnt);
    end

    // asynchronous reset between edges while a redirect is pending
    stall = 1'b0; pc_src = 2'b01; imm_op = 32'h40;
    #3 rst = 1'b1;
    #1 chk_all("async_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    #2 rst = 1'b0; pc_src = 2'b00;
    @(posedge clk); #1;
    chk_all("post_rst", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 32'd1);

    m_pc = 32'h4; m_instr = 32'h0050_0093; m_ipc = 32'h0; m_ipc4 = 32'h4; m_valid = 1'b1; m_cnt = 32'd1;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      pc_src = 2'($urandom_range(0, 3));
      imm_op = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
      jalr_base = $urandom;
      if (!stall) begin
        if (pc_src == 2'b01 || pc_src == 2'b10) begin
          m_pc = (pc_src == 2'b01) ? m_ipc + imm_op : (jalr_base + imm_op) & ~32'd3;
          m_instr = NOP; m_ipc = 32'd0; m_ipc4 = 32'd0; m_valid = 1'b0;
        end else begin
          m_instr = imem(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
          m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
        end
      end
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
